// File: rtl/accum_capture_sequencer_if.sv
// accum_capture_sequencer_if: run control, trigger inputs and status between controller and capture sequencer
interface accum_capture_sequencer_if;
  logic       start, abort, risingEdge, autoTrigEn, dataEmpty;
  logic [7:0] inputData, threshold, numEvents;
  logic       accumRst, dataCaptureStrobe, busy, done, startRejected, timeoutFlag;
  logic [8:0] eventCount;
  modport master (
    output start, abort, inputData, threshold, risingEdge, autoTrigEn, numEvents, dataEmpty,
    input  accumRst, dataCaptureStrobe, busy, done, startRejected, timeoutFlag, eventCount
  );
  modport slave (
    input  start, abort, inputData, threshold, risingEdge, autoTrigEn, numEvents, dataEmpty,
    output accumRst, dataCaptureStrobe, busy, done, startRejected, timeoutFlag, eventCount
  );
endinterface

// File: rtl/accum_capture_sequencer.sv
// accum_capture_sequencer: clears the accumulator, arms on a threshold crossing or timeout and sequences capture windows
module accum_capture_sequencer #(
  parameter int CLEAR_LEN   = 4,
  parameter int WINDOW_LEN  = 132,
  parameter int HOLDOFF_LEN = 16,
  parameter int TIMEOUT_LEN = 65535
) (
  input logic clk,
  input logic rst,
  accum_capture_sequencer_if.slave bus
);
  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_CLEAR   = 6'b000010,
    S_ARMED   = 6'b000100,
    S_CAPTURE = 6'b001000,
    S_HOLDOFF = 6'b010000,
    S_DONE    = 6'b100000
  } state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  prev_q, prev_d, thr_q, thr_d, num_q, num_d;
  logic        prev_vld_q, prev_vld_d, rise_q, rise_d, auto_q, auto_d, tflag_q, tflag_d;
  logic [8:0]  ev_q, ev_d, target;
  logic        acc_rst_q, strobe_q, strobe_d, busy_q, done_q, rej_q, rej_d;
  logic        trig, tmo;
  assign target = num_q == 8'd0 ? 9'd256 : {1'b0, num_q};
  assign tmo    = cnt_q == 16'(TIMEOUT_LEN - 1);
  assign trig   = prev_vld_q && (rise_q
    ? ($signed(prev_q) < $signed(thr_q) && $signed(bus.inputData) >= $signed(thr_q))
    : ($signed(prev_q) > $signed(thr_q) && $signed(bus.inputData) <= $signed(thr_q)));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    prev_d     = bus.inputData;
    prev_vld_d = state_q == S_ARMED;
    thr_d      = thr_q;
    rise_d     = rise_q;
    auto_d     = auto_q;
    num_d      = num_q;
    ev_d       = ev_q;
    tflag_d    = tflag_q;
    strobe_d   = 1'b0;
    rej_d      = 1'b0;
    if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (bus.start) begin
        if (bus.dataEmpty) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          thr_d   = bus.threshold;
          rise_d  = bus.risingEdge;
          auto_d  = bus.autoTrigEn;
          num_d   = bus.numEvents;
          ev_d    = '0;
          tflag_d = 1'b0;
        end else rej_d = 1'b1;
      end
      S_CLEAR: if (cnt_q == 16'(CLEAR_LEN - 1)) begin
        state_d = S_ARMED;
        cnt_d   = '0;
      end
      S_ARMED: begin
        if (tmo) begin
          tflag_d = 1'b1;
          cnt_d   = '0;
        end
        if (trig || (tmo && auto_q)) begin
          state_d  = S_CAPTURE;
          strobe_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_CAPTURE: if (cnt_q == 16'(WINDOW_LEN - 1)) begin
        ev_d    = ev_q + 9'd1;
        state_d = (ev_q + 9'd1 == target) ? S_DONE : S_HOLDOFF;
        cnt_d   = '0;
      end
      S_HOLDOFF: if (cnt_q == 16'(HOLDOFF_LEN - 1)) begin
        state_d = S_ARMED;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      thr_q      <= '0;
      rise_q     <= 1'b0;
      auto_q     <= 1'b0;
      num_q      <= '0;
      ev_q       <= '0;
      tflag_q    <= 1'b0;
      acc_rst_q  <= 1'b1;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      thr_q      <= thr_d;
      rise_q     <= rise_d;
      auto_q     <= auto_d;
      num_q      <= num_d;
      ev_q       <= ev_d;
      tflag_q    <= tflag_d;
      acc_rst_q  <= state_d == S_CLEAR;
      strobe_q   <= strobe_d;
      busy_q     <= state_d != S_IDLE;
      done_q     <= state_d == S_DONE;
      rej_q      <= rej_d;
    end
  end
  assign bus.accumRst          = acc_rst_q;
  assign bus.dataCaptureStrobe = strobe_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.startRejected     = rej_q;
  assign bus.timeoutFlag       = tflag_q;
  assign bus.eventCount        = ev_q;
endmodule

// File: tb/tb_accum_capture_sequencer.sv
// tb_accum_capture_sequencer: directed scenarios plus random traffic against a timestamp-based reference model
module tb_accum_capture_sequencer;
  localparam int CL = 4, WL = 132, HL = 16, TL = 100;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  accum_capture_sequencer_if bus();
  accum_capture_sequencer #(.CLEAR_LEN(CL), .WINDOW_LEN(WL), .HOLDOFF_LEN(HL), .TIMEOUT_LEN(TL))
    dut (.clk(clk), .rst(rst), .bus(bus));
  typedef enum int {M_IDLE, M_CLEAR, M_ARMED, M_CAPTURE, M_HOLDOFF, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int k = 0, next_at, armed_at, tmo_base, ev, num, last_in = 0, thr;
  bit rise, auto_t, tflag, m_rst, e_strobe, e_rej;
  int passed = 0, total = 0, n_str = 0, n_done = 0, s0, d0;
  task automatic check(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
  endtask
  function automatic bit crosses(int p, int c);
    return rise ? (p < thr && c >= thr) : (p > thr && c <= thr);
  endfunction
  // The model works on absolute cycle numbers: each phase ends at a known cycle index.
  task automatic model_edge();
    int cur, p;
    bit trig, tmo;
    cur = int'($signed(bus.inputData));
    p = k;
    k++;
    e_strobe = 0;
    e_rej = 0;
    m_rst = rst;
    if (rst) begin
      mode = M_IDLE; ev = 0; tflag = 0;
    end else if (bus.abort && mode != M_IDLE) mode = M_IDLE;
    else case (mode)
      M_IDLE: if (bus.start) begin
        if (bus.dataEmpty) begin
          thr = int'($signed(bus.threshold));
          rise = bus.risingEdge;
          auto_t = bus.autoTrigEn;
          num = bus.numEvents == 0 ? 256 : int'(bus.numEvents);
          ev = 0; tflag = 0;
          mode = M_CLEAR;
          next_at = k + CL;
        end else e_rej = 1;
      end
      M_CLEAR, M_HOLDOFF: if (k == next_at) begin
        mode = M_ARMED; armed_at = k; tmo_base = k;
      end
      M_ARMED: begin
        trig = p != armed_at && crosses(last_in, cur);
        tmo = p - tmo_base == TL - 1;
        if (tmo) begin tflag = 1; tmo_base = k; end
        if (trig || (tmo && auto_t)) begin
          mode = M_CAPTURE; e_strobe = 1; next_at = k + WL;
        end
      end
      M_CAPTURE: if (k == next_at) begin
        ev++;
        if (ev == num) mode = M_DONE;
        else begin mode = M_HOLDOFF; next_at = k + HL; end
      end
      default: mode = M_IDLE;
    endcase
    last_in = cur;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("accumRst", bus.accumRst, m_rst ? 1 : int'(mode == M_CLEAR));
    check("strobe", bus.dataCaptureStrobe, e_strobe);
    check("busy", bus.busy, int'(mode != M_IDLE));
    check("done", bus.done, int'(mode == M_DONE));
    check("startRejected", bus.startRejected, e_rej);
    check("timeoutFlag", bus.timeoutFlag, tflag);
    check("eventCount", bus.eventCount, ev);
    if (bus.dataCaptureStrobe) n_str++;
    if (bus.done) n_done++;
  endtask
  task automatic go();
    bus.start = 1; step(); bus.start = 0;
  endtask
  task automatic do_abort();
    bus.abort = 1; step(); bus.abort = 0;
  endtask
  initial begin
    bus.start = 0; bus.abort = 0; bus.inputData = 0; bus.threshold = 0; bus.risingEdge = 1;
    bus.autoTrigEn = 0; bus.numEvents = 1; bus.dataEmpty = 1; rst = 1;
    repeat (3) step();
    check("rst_accumRst", bus.accumRst, 1);
    check("rst_busy", bus.busy, 0);
    rst = 0; step();
    check("idle_accumRst", bus.accumRst, 0);
    // two rising events, threshold changed after latching
    bus.threshold = 8'd10; bus.numEvents = 2; bus.inputData = 8'd5;
    s0 = n_str; d0 = n_done;
    go();
    bus.threshold = 8'd100; bus.numEvents = 9;
    repeat (CL + 10) step();
    bus.inputData = 8'd20; repeat (3) step(); bus.inputData = 8'd5;
    repeat (WL + HL + 10) step();
    bus.inputData = 8'd20; repeat (3) step(); bus.inputData = 8'd5;
    repeat (WL + 5) step();
    check("a_strobes", n_str - s0, 2);
    check("a_done", n_done - d0, 1);
    check("a_events", bus.eventCount, 2);
    check("a_busy", bus.busy, 0);
    // falling at -3
    bus.threshold = 8'hFD; bus.risingEdge = 0; bus.numEvents = 3; bus.inputData = 8'd0;
    s0 = n_str;
    go();
    bus.threshold = 8'd0;
    repeat (CL + 5) step();
    bus.inputData = 8'hFD; repeat (3) step();
    check("b_strobe", n_str - s0, 1);
    bus.inputData = 8'hFC; repeat (WL + HL + 5) step();
    bus.inputData = 8'hFB; repeat (20) step();
    check("b_nostrobe", n_str - s0, 1);
    do_abort();
    check("b_abort_busy", bus.busy, 0);
    // timeout with and without auto trigger
    bus.threshold = 8'd10; bus.risingEdge = 1; bus.autoTrigEn = 1; bus.numEvents = 1; bus.inputData = 8'd0;
    go();
    repeat (CL + TL - 1) step();
    check("c_strobe_early", bus.dataCaptureStrobe, 0);
    step();
    check("c_strobe_at_timeout", bus.dataCaptureStrobe, 1);
    check("c_tflag", bus.timeoutFlag, 1);
    do_abort();
    bus.autoTrigEn = 0; s0 = n_str;
    go();
    repeat (CL + TL + 30) step();
    check("c2_strobes", n_str - s0, 0);
    check("c2_tflag", bus.timeoutFlag, 1);
    check("c2_busy", bus.busy, 1);
    do_abort();
    // rejected start, start while busy
    bus.dataEmpty = 0;
    go();
    check("d_rej", bus.startRejected, 1);
    check("d_busy", bus.busy, 0);
    step();
    check("d_rej_clear", bus.startRejected, 0);
    bus.dataEmpty = 1;
    go();
    repeat (5) step();
    bus.threshold = 8'd0;
    go();
    repeat (3) step();
    do_abort();
    // crossing on first armed cycle, then toggling during capture/holdoff
    bus.threshold = 8'd10; bus.inputData = 8'd5; s0 = n_str;
    go();
    repeat (CL) step();
    bus.inputData = 8'd20; repeat (20) step();
    check("e_first_armed", n_str - s0, 0);
    bus.inputData = 8'd5; step(); bus.inputData = 8'd20; step();
    for (int i = 0; i < WL + HL - 4; i++) begin
      bus.inputData = (i % 2) ? 8'd20 : 8'd5;
      step();
    end
    check("e_window_ignored", n_str - s0, 1);
    do_abort();
    // abort in holdoff after one of three events
    bus.numEvents = 3; bus.inputData = 8'd5; d0 = n_done;
    go();
    repeat (CL + 3) step();
    bus.inputData = 8'd20; repeat (WL + 4) step();
    do_abort();
    check("f_events", bus.eventCount, 1);
    check("f_busy", bus.busy, 0);
    check("f_done", n_done - d0, 0);
    // reset mid-capture
    bus.inputData = 8'd5;
    go();
    repeat (CL + 3) step();
    bus.inputData = 8'd20; repeat (10) step();
    rst = 1; step();
    check("g_accumRst", bus.accumRst, 1);
    check("g_busy", bus.busy, 0);
    check("g_strobe", bus.dataCaptureStrobe, 0);
    check("g_done", bus.done, 0);
    check("g_events", bus.eventCount, 0);
    rst = 0; step();
    for (int i = 0; i < 8000; i++) begin
      bus.start = $urandom_range(0, 39) == 0;
      bus.abort = $urandom_range(0, 399) == 0;
      rst = $urandom_range(0, 2999) == 0;
      bus.dataEmpty = $urandom_range(0, 3) != 0;
      bus.inputData = 8'($urandom_range(0, 40)) - 8'd20;
      bus.threshold = 8'($urandom_range(0, 20)) - 8'd10;
      bus.risingEdge = 1'($urandom_range(0, 1));
      bus.autoTrigEn = 1'($urandom_range(0, 1));
      bus.numEvents = 8'($urandom_range(1, 3));
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/accum_capture_sequencer.md
ACCUM_CAPTURE_SEQUENCER -- requirements
Module: accum_capture_sequencer

Interface
REQ-001 Parameter CLEAR_LEN, default 4, cycles accumRst is held at start of a run.
REQ-002 Parameter WINDOW_LEN, default 132, cycles from strobe until the accumulator is idle again.
REQ-003 Parameter HOLDOFF_LEN, default 16, dead cycles between end of a window and re-arm.
REQ-004 Parameter TIMEOUT_LEN, default 65535, ARMED cycles before timeout action; 16-bit counter.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle run request.
REQ-008 abort  in  1  terminate run.
REQ-009 inputData  in  8  signed ADC sample, same stream as the accumulator.
REQ-010 threshold  in  8  signed trigger level.
REQ-011 risingEdge  in  1  1 = rising-crossing trigger, 0 = falling.
REQ-012 autoTrigEn  in  1  force a strobe on timeout.
REQ-013 numEvents  in  8  events per run; 0 means 256.
REQ-014 dataEmpty  in  1  accumulator readout FIFO empty.
REQ-015 accumRst  out  1  reset to accumulator.
REQ-016 dataCaptureStrobe  out  1  one-cycle capture pulse to accumulator.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at run completion.
REQ-019 startRejected  out  1  one-cycle pulse when start is refused.
REQ-020 timeoutFlag  out  1  sticky; set on any timeout in the current run.
REQ-021 eventCount  out  9  events completed in the current run.

Function
REQ-022 States: IDLE, CLEAR, ARMED, CAPTURE, HOLDOFF, DONE; one-hot encoding.
REQ-023 IDLE: start with dataEmpty=1 -> CLEAR, latching threshold, risingEdge, autoTrigEn and numEvents; clears eventCount and timeoutFlag.
REQ-024 IDLE: start with dataEmpty=0 -> stay IDLE; startRejected pulses the next cycle.
REQ-025 start outside IDLE is ignored; input changes after latching have no effect until the next accepted start.
REQ-026 CLEAR: accumRst=1 for exactly CLEAR_LEN cycles, then -> ARMED.
REQ-027 ARMED: prevSample register tracks inputData every cycle; trigger evaluation is suppressed on the first ARMED cycle (prevSample invalid).
REQ-028 Rising trigger: prevSample < threshold and inputData >= threshold, signed compare. Falling trigger: prevSample > threshold and inputData <= threshold.
REQ-029 Trigger seen in cycle N -> dataCaptureStrobe=1 in cycle N+1 only; state -> CAPTURE in cycle N+1.
REQ-030 ARMED timeout counter starts at 0 on ARMED entry and counts +1 per cycle; at TIMEOUT_LEN-1 it sets timeoutFlag.
REQ-031 Timeout with autoTrigEn=1: strobe issued as for a trigger. Timeout with autoTrigEn=0: counter restarts at 0 and the block stays ARMED.
REQ-032 Trigger and timeout in the same cycle: one strobe only; timeoutFlag is still set.
REQ-033 CAPTURE: lasts WINDOW_LEN cycles counted from the strobe cycle, then eventCount +1; new triggers are ignored.
REQ-034 After CAPTURE: if eventCount (updated) equals numEvents (0 treated as 256) -> DONE, otherwise -> HOLDOFF.
REQ-035 HOLDOFF: HOLDOFF_LEN cycles, then -> ARMED.
REQ-036 DONE: done=1 for one cycle, then -> IDLE; eventCount holds its value until the next accepted start.
REQ-037 abort in any non-IDLE state: -> IDLE next cycle; strobe and accumRst deasserted; no done pulse; eventCount and timeoutFlag hold.
REQ-038 abort in IDLE is ignored; abort together with start in IDLE: start is processed.
REQ-039 All outputs are registered.

Reset
REQ-040 rst dominates all inputs. It forces IDLE, clears all counters and prevSample valid, and drives accumRst=1 for the cycle.
REQ-041 With rst=1, outputs are: busy=0, done=0, dataCaptureStrobe=0, startRejected=0, timeoutFlag=0, eventCount=0.
REQ-042 rst asserted mid-CAPTURE: next cycle in IDLE with no strobe and no done.

Verification
REQ-043 Start with numEvents=2 and threshold=10, rising; inputData steps 5->20 twice, with gaps >= WINDOW_LEN+HOLDOFF_LEN -> two strobes, each one cycle after the crossing; done pulses after the second window; eventCount=2.
REQ-044 Falling mode with threshold=-3; samples 0,-3 -> strobe; samples -4,-5 -> no strobe.
REQ-045 No crossing, autoTrigEn=1, TIMEOUT_LEN=100 -> strobe 100 cycles after ARMED entry; timeoutFlag=1. With autoTrigEn=0 -> no strobe, timeoutFlag=1, block stays ARMED.
REQ-046 Start while dataEmpty=0 -> startRejected pulse, busy stays 0. Start while busy -> no effect.
REQ-047 Crossing during CAPTURE or HOLDOFF -> no strobe. Crossing on the first ARMED cycle -> no strobe.
REQ-048 Abort in HOLDOFF after 1 of 3 events -> IDLE, eventCount=1, no done. rst mid-run -> all outputs at reset values.
